t07_fetch_unit: RTL and testbench
=================================

Name: t07_fetch_unit

Overview:
Instruction fetch stage directly upstream of t07_control_unit. It owns the program counter and requests instruction words from the memory handler over a request/ack handshake. It latches each returned word into an instruction register and slices that register into the decode fields the control unit consumes (Op, funct3, funct7, rs2, rs3). It holds each instruction until the downstream stage accepts it, then advances the PC sequentially or redirects it on a taken branch or jump.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction register value after reset (addi x0,x0,0)

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  asynchronous active-low reset
memBusy  input  1  memory handler cannot accept a request this cycle
memAck  input  1  memInstr is valid this cycle
memInstr  input  32  instruction word returned by the memory handler
fetchReq  output  1  fetch request to the memory handler
fetchAddr  output  32  word address of the request (= pc)
instrReady  input  1  downstream accepts the held instruction this cycle
pcLoad  input  1  taken branch or jump for the held instruction; sampled only on accept
pcTarget  input  32  redirect target; sampled only with pcLoad
instrValid  output  1  instr and decode fields hold a valid, unconsumed instruction
instr  output  32  instruction register
pc  output  32  address of the instruction in instr
pcPlus4  output  32  pc + 4, for jal/jalr link
Op  output  7  instr[6:0]
rd  output  5  instr[11:7]
funct3  output  3  instr[14:12]
rs1  output  5  instr[19:15]
rs2  output  5  instr[24:20]
funct7  output  7  instr[31:25]
rs3  output  5  instr[31:27] (FPU fused ops)

Behaviour:
- Reset is asynchronous and active-low; it acts immediately, including mid-transaction. Reset values: state FETCH, pc = RESET_PC, instr = NOP_INSTR, instrValid = 0, fetchReq = 0.
- FSM states: FETCH, WAIT, HOLD.
- FETCH:
  - Outputs: fetchReq = 1, fetchAddr = pc.
  - If memBusy = 1, stay in FETCH with the request held.
  - If memBusy = 0, the request is accepted and the FSM moves to WAIT.
  - memAck in FETCH is ignored.
- WAIT:
  - Outputs: fetchReq = 0.
  - On memAck = 1, instr <= memInstr and the FSM moves to HOLD.
  - With no memAck, stay in WAIT indefinitely (no timeout).
- HOLD:
  - Outputs: instrValid = 1; instr, pc and all decode fields stable.
  - memAck is ignored.
  - On instrReady = 1: if pcLoad = 1, pc <= {pcTarget[31:2], 2'b00}; otherwise pc <= pc + 4. The FSM moves to FETCH and instrValid drops in the same edge.
  - pcLoad or pcTarget without instrReady has no effect.
- instrValid is a registered state decode (state == HOLD). Decode fields and pcPlus4 are combinational from the instr and pc registers.
- Timing: minimum latency is request cycle 0, memAck cycle 1, instrValid high cycle 2. Best-case throughput is 1 instruction per 3 cycles.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000. pcPlus4 wraps identically.
- Misaligned redirect targets are silently word-aligned by clearing bits [1:0]. No trap is raised.
- instr changes only on the memAck edge in WAIT. It is never overwritten while instrValid = 1.

Test Plan:
- Reset: hold nrst = 0, then release → pc = 0, instr = 32'h13, instrValid = 0. First cycle after release: fetchReq = 1, fetchAddr = 0.
- Sequential fetch: memBusy = 0, memAck one cycle after the request with memInstr = 32'h00B50533 (add), instrReady = 1 → instrValid high 2 cycles after the request. Check Op = 7'h33, funct3 = 0, funct7 = 0, rs2 = 11, rd = 10. Next fetchAddr = 4.
- Backpressure: instrReady = 0 for 5 cycles → instrValid stays 1, instr/pc unchanged, fetchReq = 0 throughout. A stray memAck with a different memInstr does not alter instr.
- Redirect: at pc = 8, accept with pcLoad = 1 and pcTarget = 32'h0000_0103 → next fetchAddr = 32'h0000_0100. pcLoad asserted without instrReady → no PC change.
- memBusy stall and wrap: memBusy = 1 for 3 cycles in FETCH → fetchReq stays high with a stable address; the request is accepted in the cycle memBusy falls. With pc = 32'hFFFF_FFFC, pcPlus4 = 0, and after accept fetchAddr = 0.
- Reset mid-operation: assert nrst = 0 while in WAIT → same-cycle (asynchronous) return to reset values. A late memAck after release is ignored.

Source files
------------

// File: rtl/t07_fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from the memory handler,
// holds each instruction (with decode fields) until the downstream stage accepts it.
module t07_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        memBusy,
  input  logic        memAck,
  input  logic [31:0] memInstr,
  output logic        fetchReq,
  output logic [31:0] fetchAddr,
  input  logic        instrReady,
  input  logic        pcLoad,
  input  logic [31:0] pcTarget,
  output logic        instrValid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic [6:0]  Op,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [4:0]  rs3
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_fetch_req;
  logic              r_instr_valid;
  logic [XLEN-1:0]   r_instr;
  logic [XLEN-1:0]   r_pc;
  logic              w_load_instr;
  logic              w_accept;
  logic [XLEN-1:0]   w_next_pc;

  // Next-state logic; a request only counts once it has actually been presented.
  always_comb begin
    w_next_state = r_state;
    w_load_instr = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (r_fetch_req && !memBusy) begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (memAck) begin
          w_load_instr = 1'b1;
          w_next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instrReady) begin
          w_accept     = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  assign w_next_pc = pcLoad ? (pcTarget & ALIGN_MASK) : (r_pc + PC_STEP);

  // State, registered handshake outputs, instruction and PC registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state       <= S_FETCH;
      r_fetch_req   <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= NOP_INSTR;
      r_pc          <= RESET_PC;
    end else begin
      r_state       <= w_next_state;
      r_fetch_req   <= (w_next_state == S_FETCH);
      r_instr_valid <= (w_next_state == S_HOLD);
      if (w_load_instr) begin
        r_instr <= memInstr;
      end
      if (w_accept) begin
        r_pc <= w_next_pc;
      end
    end
  end

  assign fetchReq   = r_fetch_req;
  assign fetchAddr  = r_pc;
  assign instrValid = r_instr_valid;
  assign instr      = r_instr;
  assign pc         = r_pc;
  assign pcPlus4    = r_pc + PC_STEP;

  assign Op     = r_instr[6:0];
  assign rd     = r_instr[11:7];
  assign funct3 = r_instr[14:12];
  assign rs1    = r_instr[19:15];
  assign rs2    = r_instr[24:20];
  assign funct7 = r_instr[31:25];
  assign rs3    = r_instr[31:27];

endmodule

// File: tb/tb_t07_fetch_unit.sv
// Self-checking bench for t07_fetch_unit: directed corner cases plus randomized
// fetch transactions checked against a transaction-level PC/instruction model.
module tb_t07_fetch_unit;

  logic        clk;
  logic        nrst;
  logic        memBusy;
  logic        memAck;
  logic [31:0] memInstr;
  logic        fetchReq;
  logic [31:0] fetchAddr;
  logic        instrReady;
  logic        pcLoad;
  logic [31:0] pcTarget;
  logic        instrValid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [6:0]  Op;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [4:0]  rs3;

  int unsigned n_vec;
  int unsigned n_err;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;

  t07_fetch_unit dut (
    .clk        (clk),
    .nrst       (nrst),
    .memBusy    (memBusy),
    .memAck     (memAck),
    .memInstr   (memInstr),
    .fetchReq   (fetchReq),
    .fetchAddr  (fetchAddr),
    .instrReady (instrReady),
    .pcLoad     (pcLoad),
    .pcTarget   (pcTarget),
    .instrValid (instrValid),
    .instr      (instr),
    .pc         (pc),
    .pcPlus4    (pcPlus4),
    .Op         (Op),
    .rd         (rd),
    .funct3     (funct3),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct7     (funct7),
    .rs3        (rs3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decode fields recomputed from the RISC-V bit positions of the expected word.
  task automatic chk_fields(input logic [31:0] w);
    chk("op",     32'(Op),     32'(w[6:0]));
    chk("rd",     32'(rd),     32'(w[11:7]));
    chk("funct3", 32'(funct3), 32'(w[14:12]));
    chk("rs1",    32'(rs1),    32'(w[19:15]));
    chk("rs2",    32'(rs2),    32'(w[24:20]));
    chk("funct7", 32'(funct7), 32'(w[31:25]));
    chk("rs3",    32'(rs3),    32'(w[31:27]));
  endtask

  // One full fetch transaction, entered and left in FETCH with the request visible.
  task automatic do_instr(input logic [31:0] word, input int busy_cyc, input int ack_dly,
                          input int hold_cyc, input logic ld, input logic [31:0] tgt);
    chk("req_entry",  32'(fetchReq), 32'd1);
    chk("addr_entry", fetchAddr, exp_pc);
    for (int i = 0; i < busy_cyc; i++) begin
      memBusy = 1'b1;
      memAck  = 1'($urandom);
      memInstr = $urandom;
      step();
      chk("req_busy",  32'(fetchReq), 32'd1);
      chk("addr_busy", fetchAddr, exp_pc);
      chk("instr_busy", instr, exp_instr);
    end
    memBusy = 1'b0;
    memAck  = 1'($urandom);
    memInstr = $urandom;
    step();
    chk("req_wait", 32'(fetchReq), 32'd0);
    chk("instr_wait", instr, exp_instr);
    memAck = 1'b0;
    for (int i = 0; i < ack_dly; i++) begin
      memBusy = 1'($urandom);
      step();
      chk("valid_wait", 32'(instrValid), 32'd0);
      chk("req_wait2",  32'(fetchReq), 32'd0);
    end
    memAck   = 1'b1;
    memInstr = word;
    step();
    exp_instr = word;
    chk("valid_hold", 32'(instrValid), 32'd1);
    chk("instr_load", instr, exp_instr);
    chk("pc_hold",    pc, exp_pc);
    chk("pcplus4",    pcPlus4, exp_pc + 32'd4);
    chk_fields(exp_instr);
    for (int i = 0; i < hold_cyc; i++) begin
      instrReady = 1'b0;
      pcLoad     = 1'($urandom);
      pcTarget   = $urandom;
      memAck     = 1'($urandom);
      memInstr   = $urandom;
      memBusy    = 1'($urandom);
      step();
      chk("valid_bp", 32'(instrValid), 32'd1);
      chk("instr_bp", instr, exp_instr);
      chk("pc_bp",    pc, exp_pc);
      chk("req_bp",   32'(fetchReq), 32'd0);
    end
    memAck     = 1'b0;
    memBusy    = 1'b0;
    instrReady = 1'b1;
    pcLoad     = ld;
    pcTarget   = tgt;
    step();
    exp_pc = ld ? (tgt & 32'hFFFF_FFFC) : (exp_pc + 32'd4);
    instrReady = 1'b0;
    pcLoad     = 1'b0;
    chk("valid_acc", 32'(instrValid), 32'd0);
    chk("req_acc",   32'(fetchReq), 32'd1);
    chk("addr_acc",  fetchAddr, exp_pc);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    nrst = 1'b0;
    memBusy = 1'b0;
    memAck = 1'b0;
    memInstr = 32'h0;
    instrReady = 1'b0;
    pcLoad = 1'b0;
    pcTarget = 32'h0;
    exp_pc = 32'h0;
    exp_instr = 32'h0000_0013;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc",    pc, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_valid", 32'(instrValid), 32'd0);
    chk("rst_req",   32'(fetchReq), 32'd0);
    nrst = 1'b1;
    step();
    chk("post_rst_req",  32'(fetchReq), 32'd1);
    chk("post_rst_addr", fetchAddr, 32'h0);

    // add x10,x10,x11 at pc 0: minimum latency, then pc 4, then redirect at pc 8
    do_instr(32'h00B5_0533, 0, 0, 0, 1'b0, 32'h0);
    chk("add_op",     32'(Op), 32'h33);
    chk("add_funct3", 32'(funct3), 32'd0);
    chk("add_funct7", 32'(funct7), 32'd0);
    chk("add_rs2",    32'(rs2), 32'd11);
    chk("add_rd",     32'(rd), 32'd10);
    chk("seq_addr",   fetchAddr, 32'h4);
    do_instr(32'h0000_0013, 0, 1, 5, 1'b0, 32'h0);
    chk("pc8_addr", fetchAddr, 32'h8);
    do_instr(32'h0040_006F, 3, 0, 2, 1'b1, 32'h0000_0103);
    chk("redir_addr", fetchAddr, 32'h100);

    // Wrap: redirect to a misaligned top address, then sequential step wraps to 0
    do_instr(32'h0000_0067, 0, 0, 0, 1'b1, 32'hFFFF_FFFF);
    chk("wrap_addr", fetchAddr, 32'hFFFF_FFFC);
    do_instr(32'h1234_5678, 1, 0, 1, 1'b0, 32'h0);
    chk("wrap_zero", fetchAddr, 32'h0);

    for (int n = 0; n < 40; n++) begin
      do_instr($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 4)), 1'($urandom), $urandom);
    end

    // Asynchronous reset while waiting on memory, then a late ack is ignored
    memBusy = 1'b0;
    step();
    chk("mid_wait_req", 32'(fetchReq), 32'd0);
    #2;
    nrst = 1'b0;
    #1;
    exp_pc = 32'h0;
    exp_instr = 32'h0000_0013;
    chk("arst_pc",    pc, 32'h0);
    chk("arst_instr", instr, 32'h0000_0013);
    chk("arst_valid", 32'(instrValid), 32'd0);
    chk("arst_req",   32'(fetchReq), 32'd0);
    step();
    memAck   = 1'b1;
    memInstr = 32'hDEAD_BEEF;
    nrst = 1'b1;
    step();
    memAck = 1'b0;
    chk("late_ack_valid", 32'(instrValid), 32'd0);
    chk("late_ack_instr", instr, 32'h0000_0013);
    chk("late_ack_req",   32'(fetchReq), 32'd1);
    do_instr(32'hABCD_0013, 0, 0, 0, 1'b0, 32'h0);
    chk("final_addr", fetchAddr, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
